// File: rtl/msg_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : msg_sched                                                       |
// | Purpose  : SHA-256 message schedule generator. Loads one 512-bit block as  |
// |            sixteen 32-bit words (M0 first) and streams W0..W63, deriving   |
// |            W16..W63 on the fly in a 16-entry circular buffer.              |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            in_valid/in_ready/in_data[31:0]   - message word stream         |
// |            out_valid/out_ready/out_data[31:0]/out_last - schedule stream   |
// |            w_idx[5:0] - index of out_data (only with MSG_SCHED_IDX_EN)     |
// | Options  : define MSG_SCHED_IDX_EN to add the w_idx output.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module msg_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last
`ifdef MSG_SCHED_IDX_EN
  ,
  output logic [5:0]  w_idx
`endif
);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_in_hs;
  logic        w_out_hs;

  logic [31:0] r_buf [16];
  logic [5:0]  r_t;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic        r_out_last;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Next index n = t+1 and its buffer slot. The four taps W[n-2], W[n-7],
  // W[n-15], W[n-16] are found by wrapping the 4-bit slot index; W[n-16]
  // shares slot n mod 16, which is exactly the slot W[n] overwrites.
  logic [5:0]  w_n;
  logic [3:0]  w_s;
  logic [31:0] w_gen;
  logic [31:0] w_next;

  assign w_n    = r_t + 6'd1;
  assign w_s    = w_n[3:0];
  assign w_gen  = sig1(r_buf[w_s - 4'd2]) + r_buf[w_s - 4'd7]
                + sig0(r_buf[w_s - 4'd15]) + r_buf[w_s];
  assign w_next = (w_n[5:4] != 2'd0) ? w_gen : r_buf[w_s];

  // in_ready is a pure decode of the state flop, so no path from out_ready.
  assign in_ready  = (r_state == LOAD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_hs     = 1'b0;
    w_out_hs    = 1'b0;
    case (r_state)
      LOAD: begin
        w_in_hs = in_valid;
        if (in_valid && (r_t[3:0] == 4'd15)) w_state_nxt = EMIT;
      end
      EMIT: begin
        w_out_hs = r_out_valid && out_ready;
        if (w_out_hs && (r_t == 6'd63)) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

`ifdef MSG_SCHED_IDX_EN
  logic [5:0] r_idx;
  assign w_idx = r_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_buf[i] <= 32'd0;
      r_t         <= 6'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_last  <= 1'b0;
`ifdef MSG_SCHED_IDX_EN
      r_idx       <= 6'd0;
`endif
    end else begin
      if (w_in_hs) begin
        r_buf[r_t[3:0]] <= in_data;
        if (r_t[3:0] == 4'd15) begin
          // Slot 0 already holds M0; only slot 15 is written on this edge.
          r_out_data  <= r_buf[0];
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b0;
          r_t         <= 6'd0;
`ifdef MSG_SCHED_IDX_EN
          r_idx       <= 6'd0;
`endif
        end else begin
          r_t <= r_t + 6'd1;
        end
      end

      if (w_out_hs) begin
        if (r_t == 6'd63) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_t         <= 6'd0;
        end else begin
          r_out_data <= w_next;
          r_out_last <= (w_n == 6'd63);
          r_t        <= w_n;
          if (w_n[5:4] != 2'd0) r_buf[w_s] <= w_gen;
`ifdef MSG_SCHED_IDX_EN
          r_idx      <= w_n;
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msg_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_msg_sched                                                    |
// | Purpose  : Self-checking bench for msg_sched against a plain-arithmetic    |
// |            SHA-256 schedule model (W[i] from W[i-2..i-16]).                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_msg_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
`ifdef MSG_SCHED_IDX_EN
  logic [5:0]  w_idx;
`endif

  msg_sched u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef MSG_SCHED_IDX_EN
    ,
    .w_idx     (w_idx)
`endif
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] abc_ref [4];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic compute_model();
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    compute_model();
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    compute_model();
  endtask

  // Present blk[0..15]; with gaps, in_valid is randomly dropped and junk data
  // is shown on idle cycles so only handshaken words may be stored.
  task automatic load_block(input bit gaps);
    int i = 0;
    int budget = 0;
    bit hs;
    while (i < 16 && budget < 200) begin
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = in_valid ? blk[i] : $urandom;
      check("in_ready_load", {31'b0, in_ready}, 32'd1);
      check("out_valid_load", {31'b0, out_valid}, 32'd0);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      budget++;
    end
    if (i < 16) check("load_timeout", 32'(i), 32'd16);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // Consume all 64 words. stall_at holds out_ready low for 5 cycles at that
  // index; overrun drives in_valid with junk; rst_at pulses reset at that index.
  task automatic drain(input int stall_at, input bit overrun, input bit rand_bp,
                       input int rst_at, input bit abc);
    int t = 0;
    int budget = 0;
    int stall = 0;
    bit hs;
    while (t < 64 && budget < 400) begin
      if (t == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        return;
      end
      check("out_valid", {31'b0, out_valid}, 32'd1);
      check("out_data", out_data, exp_w[t]);
      check("out_last", {31'b0, out_last}, {31'b0, (t == 63)});
      check("in_ready_emit", {31'b0, in_ready}, 32'd0);
      if (abc && t >= 16 && t <= 19) check("abc_const", out_data, abc_ref[t-16]);
`ifdef MSG_SCHED_IDX_EN
      check("w_idx", {26'b0, w_idx}, 32'(t));
`endif
      if (t == stall_at && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else if (rand_bp) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      in_valid = overrun;
      in_data  = $urandom;
      hs = out_ready;
      @(posedge clk); #1;
      if (hs) t++;
      budget++;
    end
    if (t < 64) check("drain_timeout", 32'(t), 32'd64);
    in_valid = 1'b0;
    check("out_valid_after", {31'b0, out_valid}, 32'd0);
    check("in_ready_after", {31'b0, in_ready}, 32'd1);
    check("out_last_after", {31'b0, out_last}, 32'd0);
  endtask

  initial begin
    abc_ref[0] = 32'h61626380;
    abc_ref[1] = 32'h000F0000;
    abc_ref[2] = 32'h7DA86405;
    abc_ref[3] = 32'h600003C6;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_last", {31'b0, out_last}, 32'd0);
`ifdef MSG_SCHED_IDX_EN
    check("reset_w_idx", {26'b0, w_idx}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" block, full rate
    set_abc();
    load_block(1'b0);
    drain(-1, 1'b0, 1'b0, -1, 1'b1);

    // all-zero block
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    compute_model();
    load_block(1'b0);
    drain(-1, 1'b0, 1'b0, -1, 1'b0);

    // backpressure on W20
    set_random();
    load_block(1'b0);
    drain(20, 1'b0, 1'b0, -1, 1'b0);

    // input gaps, overrun during EMIT, random backpressure
    for (int k = 0; k < 4; k++) begin
      set_random();
      load_block(1'b1);
      drain(-1, 1'b1, (k != 0), -1, 1'b0);
    end

    // reset mid-EMIT at t=30, then a clean "abc" block
    set_random();
    load_block(1'b0);
    drain(-1, 1'b0, 1'b0, 30, 1'b0);
    set_abc();
    load_block(1'b0);
    drain(-1, 1'b0, 1'b0, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msg_sched.md
# msg_sched

SHA-256 message schedule generator. Accepts one 512-bit block as sixteen 32-bit words over a valid/ready input stream. Emits the 64 schedule words W0..W63 over a valid/ready output stream, computing W16..W63 internally with the sigma0/sigma1 functions. It sits between the block padder/loader and the compression round engine, and is the producer-side counterpart that feeds the schedule words the round logic consumes.

## Interface
- No parameters (word width fixed at 32, block 16 words, schedule 64 words).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts an input word.
- in_data  in  32  message word, big-endian word order, M0 first.
- out_valid  out  1  schedule word valid.
- out_ready  in  1  consumer accepts the schedule word.
- out_data  out  32  schedule word W[t].
- out_last  out  1  high with W63.
- w_idx  out  6  index t of out_data; present only with MSG_SCHED_IDX_EN.

## Operation
- Two states:
  - LOAD: reset state.
  - EMIT.
- Storage: 16×32 circular buffer; word W[t] lives in slot t mod 16. A 6-bit counter t.
- LOAD behaviour:
  - in_ready=1, out_valid=0.
  - Each in_valid&&in_ready handshake writes in_data to slot t and increments t.
  - On the handshake of word 15, out_data<=slot0 (W0), out_valid<=1, t<=0, and the state moves to EMIT.
- EMIT behaviour:
  - in_ready=0; in_valid is ignored and in_data is not sampled.
  - On each out_valid&&out_ready handshake at index t<63, out_data<=W[t+1] and t increments.
  - For t+1<16, W[t+1] is read from slot t+1.
  - For t+1≥16, W[t+1] = sig1(W[t-1]) + W[t-6] + sig0(W[t-14]) + W[t-15], mod 2^32. It is written into slot (t+1) mod 16 on the same edge, overwriting W[t-15].
- sig0(x) = rotr7 ^ rotr18 ^ shr3. sig1(x) = rotr17 ^ rotr19 ^ shr10. Both are combinational inside the block, and all additions are 32-bit with carry-out discarded.
- out_last = (t==63) while out_valid.
- On the W63 handshake: out_valid<=0, out_last<=0, t<=0, state<=LOAD.
- Backpressure: while out_valid&&!out_ready, out_data, out_last, t and the buffer hold.
- Reset mid-operation (either state): the partial block is discarded and the block returns to LOAD with t=0.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_last=0, w_idx=0.
  - Buffer cleared to 0, state LOAD.
- Input throughput: one word per cycle; 16 cycles minimum per block.
- First-output latency: W0 is valid the cycle after the in handshake of M15.
- Output throughput: one word per cycle with out_ready held high; 64 cycles minimum. Minimum block period is 80 cycles.
- in_ready rises the cycle after the W63 handshake. No overlap between blocks.
- All outputs are registered; no combinational path from in_* to out_* or from out_ready to in_ready.

## Configuration
- MSG_SCHED_IDX_EN defined:
  - Adds output port w_idx[5:0], registered and equal to t of the current out_data.
  - Updated on the same edges as out_data; reset value 0.
- Undefined: port and logic absent. All other behaviour is identical.

## Test plan
- "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), out_ready=1:
  - W0..W15 equal the inputs.
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6.
  - All 64 words match the reference model; out_last only on W63.
- All-zero block: 64 outputs all 0x00000000; out_valid high for exactly 64 consecutive cycles; in_ready returns 1 the cycle after the W63 handshake.
- Backpressure: drop out_ready for 5 cycles while W20 is presented.
  - out_data stays at W20 and t does not advance.
  - Resuming gives W21 next, and the full sequence still matches the model.
- Input gaps and overrun:
  - in_valid toggled randomly during LOAD: only handshaken words are stored.
  - in_valid=1 with arbitrary data during EMIT: in_ready=0 and the output sequence is unaffected.
- Reset mid-EMIT at t=30: outputs return to reset values immediately (async). Then load the "abc" block; output is correct from W0.
- MSG_SCHED_IDX_EN build: w_idx steps 0..63 in lockstep with out_data and holds during backpressure.
